// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display driver:
// digit count, control-word field offsets and the hex-to-segment table.
package seg_pkg;

  localparam int DIGITS    = 8;
  localparam int IDX_W     = 3;

  localparam int BLANK_LSB = 0;
  localparam int BLINK_LSB = 8;
  localparam int DP_LSB    = 16;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] HEX7 [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-segment decoder producing the active-low
// {g..a} pattern for one hex digit.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg7
);

  assign o_seg7 = HEX7[i_nibble];

endmodule

// File: rtl/seg_display.sv
// Multiplexed common-anode 7-segment scanner: shadowed data/control registers,
// round-robin digit scan with deghost gap, blanking, blink and decimal points.
module seg_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 500,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [31:0] wr_data,
  output logic        frame_sync,
  output logic [7:0]  digit_sel,
  output logic [7:0]  seg
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYC);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [31:0]      r_shData;
  logic [23:0]      r_shCtrl;
  logic [31:0]      r_actData;
  logic [23:0]      r_actCtrl;
  logic [PRE_W-1:0] r_pre;
  logic [IDX_W-1:0] r_idx;
  logic [FRM_W-1:0] r_frameCnt;
  logic             r_blinkPh;
  logic [7:0]       r_digitSel;
  logic [7:0]       r_seg;

  logic             w_slotEnd;
  logic             w_frameEnd;
  logic [31:0]      w_nextData;
  logic [23:0]      w_nextCtrl;
  logic [7:0]       w_blank;
  logic [7:0]       w_blink;
  logic [7:0]       w_dp;
  logic             w_dark;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg7;

  assign w_slotEnd  = (r_pre == PRE_LAST);
  assign w_frameEnd = w_slotEnd && (r_idx == IDX_LAST);

  // A write landing on the frame boundary goes straight into the new frame
  assign w_nextData = (wr_en && !wr_sel) ? wr_data       : r_shData;
  assign w_nextCtrl = (wr_en &&  wr_sel) ? wr_data[23:0] : r_shCtrl;

  assign w_blank  = r_actCtrl[BLANK_LSB +: DIGITS];
  assign w_blink  = r_actCtrl[BLINK_LSB +: DIGITS];
  assign w_dp     = r_actCtrl[DP_LSB    +: DIGITS];
  assign w_dark   = w_blank[r_idx] || (w_blink[r_idx] && r_blinkPh);
  assign w_nibble = r_actData[{r_idx, 2'b00} +: 4];

  seg_hex_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg7   (w_seg7)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shData <= '0;
      r_shCtrl <= '0;
    end else if (wr_en) begin
      if (wr_sel) r_shCtrl <= wr_data[23:0];
      else        r_shData <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (w_slotEnd) begin
      r_pre <= '0;
      r_idx <= w_frameEnd ? '0 : r_idx + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Active registers and blink phase only move at frame boundaries to avoid tearing
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_actData  <= '0;
      r_actCtrl  <= '0;
      r_frameCnt <= '0;
      r_blinkPh  <= 1'b0;
    end else if (w_frameEnd) begin
      r_actData <= w_nextData;
      r_actCtrl <= w_nextCtrl;
      if (r_frameCnt == FRM_LAST) begin
        r_frameCnt <= '0;
        r_blinkPh  <= ~r_blinkPh;
      end else begin
        r_frameCnt <= r_frameCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_digitSel <= SEG_OFF;
      r_seg      <= SEG_OFF;
    end else if ((r_pre < BLANK_END) || w_dark) begin
      r_digitSel <= SEG_OFF;
      r_seg      <= SEG_OFF;
    end else begin
      r_digitSel <= ~(8'b1 << r_idx);
      r_seg      <= {~w_dp[r_idx], w_seg7};
    end
  end

  assign frame_sync = w_frameEnd;
  assign digit_sel  = r_digitSel;
  assign seg        = r_seg;

endmodule

// File: tb/tb_seg_display.sv
// Directed bench for seg_display with a 4-cycle slot, 1-cycle deghost
// and 2-frame blink half-period (32 clocks per frame).
module tb_seg_display;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en;
  logic        wr_sel;
  logic [31:0] wr_data;
  logic        frame_sync;
  logic [7:0]  digit_sel;
  logic [7:0]  seg;

  int errors = 0;
  int checks = 0;

  logic [7:0] capSel  [128];
  logic [7:0] capSeg  [128];
  logic       capSync [128];

  // Full active-low segment bytes with the decimal point off
  logic [7:0] segTab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  seg_display #(
    .SCAN_DIV     (4),
    .BLANK_CYC    (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .frame_sync (frame_sync),
    .digit_sel  (digit_sel),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected {digit_sel, seg} for slot position p of digit d
  function automatic logic [15:0] expSlot(int d, int p, logic [31:0] data,
                                          logic [7:0] dark, logic [7:0] dp);
    logic [7:0] s;
    logic [7:0] sel;
    logic [3:0] nib;
    if (p == 0 || dark[d]) return 16'hFFFF;
    nib = data[4*d +: 4];
    s   = segTab[nib];
    if (dp[d]) s[7] = 1'b0;
    sel    = 8'hFF;
    sel[d] = 1'b0;
    return {sel, s};
  endfunction

  task automatic writeReg(input logic sel, input logic [31:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Wait for frame_sync, then record nFrames of outputs; sample k = digit k/4, slot k%4
  task automatic capture(input int nFrames, input bit doWrite, input int wrAtK,
                         input logic sel, input logic [31:0] data);
    int waitCyc;
    waitCyc = 0;
    while (frame_sync !== 1'b1 && waitCyc < 100) begin
      @(negedge clk);
      waitCyc++;
    end
    checks++;
    if (frame_sync !== 1'b1) begin
      errors++;
      $display("[TB] FAIL frame_sync_wait: got %b want 1 within 100 cycles", frame_sync);
    end
    @(negedge clk);
    for (int k = 0; k < 32 * nFrames; k++) begin
      @(negedge clk);
      wr_en      = 1'b0;
      capSel[k]  = digit_sel;
      capSeg[k]  = seg;
      capSync[k] = frame_sync;
      if (doWrite && k == wrAtK) begin
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_data = data;
      end
    end
  endtask

  task automatic test_reset;
    logic [15:0] e;
    rstn = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (digit_sel !== 8'hFF) begin errors++; $display("[TB] FAIL rst_sel: got %h want ff", digit_sel); end
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("[TB] FAIL rst_seg: got %h want ff", seg); end
    checks++;
    if (frame_sync !== 1'b0) begin errors++; $display("[TB] FAIL rst_sync: got %b want 0", frame_sync); end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (digit_sel !== 8'hFF) begin errors++; $display("[TB] FAIL first_deghost: got %h want ff", digit_sel); end
    @(negedge clk);
    checks++;
    if (digit_sel !== 8'hFE) begin errors++; $display("[TB] FAIL first_lit_sel: got %h want fe", digit_sel); end
    checks++;
    if (seg !== 8'hC0) begin errors++; $display("[TB] FAIL first_lit_seg: got %h want c0", seg); end
    capture(1, 1'b0, 0, 1'b0, 32'h0);
    for (int k = 0; k < 32; k++) begin
      e = expSlot(k / 4, k % 4, 32'h0, 8'h00, 8'h00);
      checks++;
      if (capSel[k] !== e[15:8]) begin errors++; $display("[TB] FAIL scan_sel k=%0d: got %h want %h", k, capSel[k], e[15:8]); end
      checks++;
      if (capSeg[k] !== e[7:0]) begin errors++; $display("[TB] FAIL scan_seg k=%0d: got %h want %h", k, capSeg[k], e[7:0]); end
    end
    checks++;
    if (capSync[30] !== 1'b1) begin errors++; $display("[TB] FAIL sync_pulse: got %b want 1", capSync[30]); end
    checks++;
    if (capSync[29] !== 1'b0 || capSync[31] !== 1'b0) begin
      errors++; $display("[TB] FAIL sync_width: got %b%b want 00", capSync[29], capSync[31]);
    end
  endtask

  task automatic test_data_write;
    logic [15:0] e;
    capture(2, 1'b1, 5, 1'b0, 32'h76543210);
    for (int k = 0; k < 64; k++) begin
      e = expSlot((k % 32) / 4, k % 4, (k < 32) ? 32'h0 : 32'h76543210, 8'h00, 8'h00);
      checks++;
      if (capSel[k] !== e[15:8]) begin errors++; $display("[TB] FAIL data_sel k=%0d: got %h want %h", k, capSel[k], e[15:8]); end
      checks++;
      if (capSeg[k] !== e[7:0]) begin errors++; $display("[TB] FAIL data_seg k=%0d: got %h want %h", k, capSeg[k], e[7:0]); end
    end
    checks++;
    if (capSeg[32 + 4*7 + 1] !== 8'hF8) begin errors++; $display("[TB] FAIL digit7_seg: got %h want f8", capSeg[61]); end
  endtask

  task automatic test_blank;
    logic [15:0] e;
    capture(2, 1'b1, 5, 1'b1, 32'h0000_0002);
    for (int k = 0; k < 64; k++) begin
      e = expSlot((k % 32) / 4, k % 4, 32'h76543210, (k < 32) ? 8'h00 : 8'h02, 8'h00);
      checks++;
      if (capSel[k] !== e[15:8]) begin errors++; $display("[TB] FAIL blank_sel k=%0d: got %h want %h", k, capSel[k], e[15:8]); end
      checks++;
      if (capSeg[k] !== e[7:0]) begin errors++; $display("[TB] FAIL blank_seg k=%0d: got %h want %h", k, capSeg[k], e[7:0]); end
    end
  endtask

  task automatic test_blink;
    logic [15:0] e;
    logic [7:0]  darkTab [4];
    darkTab = '{8'h00, 8'h01, 8'h01, 8'h00};
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    writeReg(1'b0, 32'h11111111);
    writeReg(1'b0, 32'hFEDCBA98);
    writeReg(1'b1, 32'h0080_0100);
    capture(4, 1'b0, 0, 1'b0, 32'h0);
    for (int k = 0; k < 128; k++) begin
      e = expSlot((k % 32) / 4, k % 4, 32'hFEDCBA98, darkTab[k / 32], 8'h80);
      checks++;
      if (capSel[k] !== e[15:8]) begin errors++; $display("[TB] FAIL blink_sel k=%0d: got %h want %h", k, capSel[k], e[15:8]); end
      checks++;
      if (capSeg[k] !== e[7:0]) begin errors++; $display("[TB] FAIL blink_seg k=%0d: got %h want %h", k, capSeg[k], e[7:0]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] e;
    writeReg(1'b1, 32'h0);
    capture(2, 1'b1, 30, 1'b0, 32'h0F1E2D3C);
    checks++;
    if (capSync[30] !== 1'b1) begin errors++; $display("[TB] FAIL coincident_sync: got %b want 1", capSync[30]); end
    for (int k = 0; k < 64; k++) begin
      e = expSlot((k % 32) / 4, k % 4, (k < 32) ? 32'hFEDCBA98 : 32'h0F1E2D3C, 8'h00, 8'h00);
      checks++;
      if (capSel[k] !== e[15:8]) begin errors++; $display("[TB] FAIL bypass_sel k=%0d: got %h want %h", k, capSel[k], e[15:8]); end
      checks++;
      if (capSeg[k] !== e[7:0]) begin errors++; $display("[TB] FAIL bypass_seg k=%0d: got %h want %h", k, capSeg[k], e[7:0]); end
    end
  endtask

  task automatic test_mid_reset;
    int waitCyc;
    waitCyc = 0;
    while (frame_sync !== 1'b1 && waitCyc < 100) begin
      @(negedge clk);
      waitCyc++;
    end
    checks++;
    if (frame_sync !== 1'b1) begin errors++; $display("[TB] FAIL mid_sync_wait: got %b want 1", frame_sync); end
    repeat (24) @(negedge clk);
    checks++;
    if (digit_sel !== 8'hDF) begin errors++; $display("[TB] FAIL pre_rst_sel: got %h want df", digit_sel); end
    checks++;
    if (seg !== 8'hF9) begin errors++; $display("[TB] FAIL pre_rst_seg: got %h want f9", seg); end
    rstn = 1'b0;
    #1;
    checks++;
    if (digit_sel !== 8'hFF) begin errors++; $display("[TB] FAIL async_rst_sel: got %h want ff", digit_sel); end
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("[TB] FAIL async_rst_seg: got %h want ff", seg); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (digit_sel !== 8'hFF) begin errors++; $display("[TB] FAIL restart_deghost: got %h want ff", digit_sel); end
    @(negedge clk);
    checks++;
    if (digit_sel !== 8'hFE) begin errors++; $display("[TB] FAIL restart_sel: got %h want fe", digit_sel); end
    checks++;
    if (seg !== 8'hC0) begin errors++; $display("[TB] FAIL restart_seg: got %h want c0", seg); end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_blank();
    test_blink();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
